// File: rtl/signal_probe.sv
// Multi-channel signal probe: a free-running heartbeat, a two-flop synchroniser
// per channel, saturating rising-edge counters, and stretched or sticky activity LEDs.
module signal_probe #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int STRETCH_LEN = 8,
  parameter int HB_W        = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         signal,
  input  logic                    clear,
  input  logic                    mode,
  output logic                    led_clk,
  output logic [N_CH-1:0]         sync_signal,
  output logic [N_CH-1:0]         led_signal,
  output logic [N_CH*CNT_W-1:0]   edge_count
);

  localparam int                SW           = 16;
  localparam logic [SW-1:0]     STRETCH_INIT = SW'(STRETCH_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

  logic [HB_W-1:0]  hb_q;
  logic [N_CH-1:0]  meta_q, sync_q, prev_q;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [N_CH-1:0]  rise, fall;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [SW-1:0]    str_q [N_CH];
  logic [SW-1:0]    str_d [N_CH];

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

  // Mode only gates whether edges set sticky flags; the stretcher runs in both modes.
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      str_d[i] = str_q[i];
    end
    if (clear) begin
      sticky_d = '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_d[i] = '0;
        str_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
        if (rise[i] || fall[i]) begin
          str_d[i] = STRETCH_INIT;
          if (mode) sticky_d[i] = 1'b1;
        end else if (str_q[i] != '0) begin
          str_d[i] = str_q[i] - 1'b1;
        end
      end
    end
  end

  // The heartbeat and synchroniser chain ignore clear on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q     <= '0;
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        str_q[i] <= '0;
      end
    end else begin
      hb_q     <= hb_q + 1'b1;
      meta_q   <= signal;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      sticky_q <= sticky_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        str_q[i] <= str_d[i];
      end
    end
  end

  assign led_clk     = hb_q[HB_W-1];
  assign sync_signal = sync_q;

  always_comb begin
    led_signal = '0;
    edge_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      led_signal[i]                = sticky_q[i] | (str_q[i] != '0);
      edge_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_signal_probe.sv
// Directed bench for signal_probe with N_CH=4, CNT_W=4, STRETCH_LEN=5, HB_W=3.
module tb_signal_probe;

  logic        clk;
  logic        rst_n;
  logic [3:0]  signal;
  logic        clear;
  logic        mode;
  logic        led_clk;
  logic [3:0]  sync_signal;
  logic [3:0]  led_signal;
  logic [15:0] edge_count;

  int checks   = 0;
  int failures = 0;

  signal_probe #(
    .N_CH(4), .CNT_W(4), .STRETCH_LEN(5), .HB_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .clear(clear), .mode(mode),
    .led_clk(led_clk), .sync_signal(sync_signal), .led_signal(led_signal),
    .edge_count(edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int ch);
    signal[ch] = 1'b1;
    ticks(2);
    signal[ch] = 1'b0;
    ticks(2);
  endtask

  initial begin
    rst_n  = 1'b0;
    signal = 4'h0;
    clear  = 1'b0;
    mode   = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_led_clk", 32'(led_clk), 32'h0);
    chk("rst_sync", 32'(sync_signal), 32'h0);
    chk("rst_led", 32'(led_signal), 32'h0);
    chk("rst_count", 32'(edge_count), 32'h0);
    rst_n = 1'b1;

    // Heartbeat: low for hb 0..3, high for 4..7
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk($sformatf("hb_%0d", n), 32'(led_clk), ((n % 8) >= 4) ? 32'h1 : 32'h0);
    end

    // Single rise on channel 0: latency and stretch length
    signal[0] = 1'b1;
    tick();
    chk("ch0_sync_k", 32'(sync_signal), 32'h0);
    tick();
    chk("ch0_sync_k1", 32'(sync_signal), 32'h1);
    chk("ch0_cnt_k1", 32'(edge_count), 32'h0);
    chk("ch0_led_k1", 32'(led_signal), 32'h0);
    tick();
    chk("ch0_cnt_k2", 32'(edge_count), 32'h0001);
    chk("ch0_led_k2", 32'(led_signal), 32'h1);
    ticks(4);
    chk("ch0_led_k6", 32'(led_signal), 32'h1);
    tick();
    chk("ch0_led_k7", 32'(led_signal), 32'h0);
    signal[0] = 1'b0;
    ticks(10);
    chk("ch0_fall_nocount", 32'(edge_count), 32'h0001);
    chk("ch0_fall_led_off", 32'(led_signal), 32'h0);

    // Saturation on channel 2
    for (int p = 0; p < 10; p++) pulse(2);
    chk("ch2_cnt_10", 32'(edge_count), 32'h0A01);
    for (int p = 0; p < 8; p++) pulse(2);
    ticks(5);
    chk("ch2_cnt_sat", 32'(edge_count), 32'h0F01);
    ticks(10);
    chk("ch2_led_off", 32'(led_signal), 32'h0);

    // Retrigger on channel 3: rise then fall three cycles later
    signal[3] = 1'b1;
    ticks(2);
    chk("ch3_led_pre", 32'(led_signal), 32'h0);
    tick();
    chk("ch3_led_k2", 32'(led_signal), 32'h8);
    signal[3] = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk($sformatf("ch3_led_k%0d", k), 32'(led_signal), 32'h8);
    end
    tick();
    chk("ch3_led_k10", 32'(led_signal), 32'h0);
    chk("ch3_cnt", 32'(edge_count), 32'h1F01);

    // Sticky mode on channel 1
    mode = 1'b1;
    pulse(1);
    ticks(100);
    chk("ch1_sticky_led", 32'(led_signal), 32'h2);
    chk("ch1_sticky_cnt", 32'(edge_count), 32'h1F11);
    mode = 1'b0;
    tick();
    chk("ch1_mode_change", 32'(led_signal), 32'h2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_led", 32'(led_signal), 32'h0);
    chk("clear_cnt", 32'(edge_count), 32'h0);

    // Clear coincident with a rise on every channel
    signal = 4'hF;
    ticks(2);
    chk("all_sync", 32'(sync_signal), 32'hF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_edge_cnt", 32'(edge_count), 32'h0);
    chk("clr_edge_led", 32'(led_signal), 32'h0);
    chk("clr_edge_sync", 32'(sync_signal), 32'hF);
    tick();
    chk("clr_edge_after", 32'(edge_count), 32'h0);

    // Simultaneous rises counted together
    signal = 4'h0;
    ticks(10);
    signal = 4'hF;
    ticks(3);
    chk("all_cnt", 32'(edge_count), 32'h1111);
    chk("all_led", 32'(led_signal), 32'hF);

    // Asynchronous reset mid-stretch, no clock edge in between
    tick();
    rst_n = 1'b0;
    #2;
    chk("async_rst_led", 32'(led_signal), 32'h0);
    chk("async_rst_cnt", 32'(edge_count), 32'h0);
    chk("async_rst_sync", 32'(sync_signal), 32'h0);
    chk("async_rst_hb", 32'(led_clk), 32'h0);
    ticks(3);
    rst_n = 1'b1;

    // Inputs already high at release
    tick();
    chk("rel_sync_1", 32'(sync_signal), 32'h0);
    chk("rel_cnt_1", 32'(edge_count), 32'h0);
    tick();
    chk("rel_sync_2", 32'(sync_signal), 32'hF);
    chk("rel_cnt_2", 32'(edge_count), 32'h0);
    tick();
    chk("rel_cnt_3", 32'(edge_count), 32'h1111);
    chk("rel_led_3", 32'(led_signal), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_probe.md
SIGNAL_PROBE -- requirements
Module: signal_probe

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of monitored signal channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of each per-channel rising-edge counter (2..32).
REQ-003 The block SHALL have parameter STRETCH_LEN, default 8, meaning number of cycles a channel LED stays lit after an edge (1..2^16-1).
REQ-004 The block SHALL have parameter HB_W, default 24, meaning width of the clock heartbeat divider (2..32).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port signal, input, N_CH bits: asynchronous monitored inputs, one bit per channel.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear of counters, stretchers and sticky flags.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = live (retriggerable stretch), 1 = sticky (LED latches on first edge).
REQ-010 The block SHALL have port led_clk, output, 1 bit: heartbeat, equal to the MSB of the heartbeat divider.
REQ-011 The block SHALL have port sync_signal, output, N_CH bits: signal after a two-flop synchroniser.
REQ-012 The block SHALL have port led_signal, output, N_CH bits: per-channel activity indicator.
REQ-013 The block SHALL have port edge_count, output, N_CH*CNT_W bits: channel i in bits [i*CNT_W +: CNT_W].

Function
REQ-014 The heartbeat divider SHALL increment by 1 every cycle and wrap from all-ones to 0; clear SHALL NOT affect it.
REQ-015 Each signal bit SHALL pass through two flops; sync_signal[i] SHALL equal signal[i] sampled two rising edges earlier.
REQ-016 A third flop per channel SHALL hold the previous sync_signal; rise = sync & ~prev, fall = ~sync & prev.
REQ-017 edge_count[i] SHALL increment by 1 on the clock edge after sync_signal[i] rises, i.e. the 3rd edge after signal[i] rises.
REQ-018 edge_count[i] SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 In mode 0, any rise or fall SHALL load the channel stretch counter with STRETCH_LEN; otherwise a nonzero counter SHALL decrement by 1 per cycle.
REQ-020 In mode 0, led_signal[i] SHALL be 1 exactly while the stretch counter is nonzero; an edge during stretch SHALL reload to STRETCH_LEN.
REQ-021 In mode 1, the first rise or fall on a channel SHALL set a sticky flag; led_signal[i] SHALL then stay 1 until clear or reset.
REQ-022 led_signal[i] SHALL be sticky_flag OR (stretch counter != 0); the stretch counter SHALL run in both modes.
REQ-023 Changing mode SHALL NOT alter counters or flags; it SHALL only change whether new edges set sticky flags.
REQ-024 When clear=1, all edge_count, stretch counters and sticky flags SHALL be 0 on that clock edge; clear SHALL override any edge in the same cycle.
REQ-025 Synchroniser flops SHALL NOT be affected by clear.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each be counted in the same cycle.

Reset
REQ-027 While rst_n=0, all flops (divider, synchronisers, previous-value flops, counters, stretchers, sticky flags) SHALL be 0, independent of clk.
REQ-028 After reset, led_clk, sync_signal, led_signal and edge_count SHALL all be 0; no edge SHALL be detected for signal bits already high at release until two edges propagate.
REQ-029 Reset asserted mid-stretch or mid-count SHALL immediately zero the state; operation SHALL resume from zero on the first edge after release.

Verification
REQ-030 Use N_CH=4, CNT_W=4, STRETCH_LEN=5, HB_W=3: free-run 16 cycles after reset -> led_clk 0 for 4 cycles, 1 for 4, period 8.
REQ-031 signal[0] 0->1 before edge k -> sync_signal[0]=1 after edge k+1, edge_count[0]=1 and led_signal[0]=1 after edge k+2, led 0 after edge k+7.
REQ-032 18 rising pulses on signal[2], mode 0 -> edge_count[2] ends at 15 (saturated); other channels stay 0.
REQ-033 Mode 0, second toggle 3 cycles after the first -> led_signal stays 1 continuously, deasserts 5 cycles after the last edge.
REQ-034 Mode 1, one pulse on signal[1], then 100 idle cycles -> led_signal[1] stays 1; clear for 1 cycle -> led_signal[1]=0, edge_count[1]=0.
REQ-035 Clear in the same cycle as a detected rise on all channels -> all edge_count 0; rst_n pulled low mid-stretch -> all outputs 0 without a clock edge.
